// File: rtl/alu_seq.sv
// alu_seq: 32-bit ALU with a bit-serial shifter and valid/ready handshakes on both sides.
// Non-shift ops finish at the accept edge. Shifts move one bit per clock.
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic [3:0]  Flags
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpSll  = 4'b0010;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0111;
    localparam logic [3:0] OpXor  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1010;
    localparam logic [3:0] OpSra  = 4'b1011;
    localparam logic [3:0] OpOr   = 4'b1100;
    localparam logic [3:0] OpAnd  = 4'b1110;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;

    logic        use_sub;
    logic [31:0] b_x;
    logic [32:0] sum;
    logic        add_c, add_v;
    logic [31:0] alu_res;
    logic        alu_c, alu_v, is_shift;
    logic [31:0] sh_next;

    // Single-cycle ALU on the incoming request. sub, slt and sltu share the adder as A + ~B + 1.
    always_comb begin
        use_sub  = (ALUControl == OpSub) || (ALUControl == OpSlt) || (ALUControl == OpSltu);
        b_x      = use_sub ? ~SrcB : SrcB;
        sum      = {1'b0, SrcA} + {1'b0, b_x} + {32'b0, use_sub};
        add_c    = sum[32];
        add_v    = (SrcA[31] == b_x[31]) && (sum[31] != SrcA[31]);
        alu_res  = 32'h0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        is_shift = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                alu_res = sum[31:0];
                alu_c   = add_c;
                alu_v   = add_v;
            end
            OpSlt: begin
                alu_res = {31'b0, sum[31] ^ add_v};
                alu_c   = add_c;
                alu_v   = add_v;
            end
            OpSltu: begin
                alu_res = {31'b0, ~add_c};
                alu_c   = add_c;
                alu_v   = add_v;
            end
            // The result only matters when shamt is 0, where the shift passes SrcA through.
            OpSll, OpSrl, OpSra: begin
                alu_res  = SrcA;
                is_shift = 1'b1;
            end
            OpXor:   alu_res = SrcA ^ SrcB;
            OpOr:    alu_res = SrcA | SrcB;
            OpAnd:   alu_res = SrcA & SrcB;
            default: alu_res = 32'h0;
        endcase
    end

    // One-bit shift step for the captured shift op.
    always_comb begin
        case (op_q)
            OpSll:   sh_next = sh_q << 1;
            OpSrl:   sh_next = sh_q >> 1;
            default: sh_next = {sh_q[31], sh_q[31:1]};
        endcase
    end

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift && (SrcB[4:0] != 5'd0)) begin
                        op_d    = ALUControl;
                        sh_d    = SrcA;
                        cnt_d   = SrcB[4:0];
                        state_d = StShift;
                    end else begin
                        res_d   = alu_res;
                        flags_d = {alu_res[31], alu_res == 32'h0, alu_c, alu_v};
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    res_d   = sh_next;
                    flags_d = {sh_next[31], sh_next == 32'h0, 2'b00};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            sh_q    <= 32'h0;
            cnt_q   <= 5'd0;
            res_q   <= 32'h0;
            flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign ALUResult = res_q;
    assign Flags     = flags_q;

endmodule
